fl_frame_arbiter: RTL and testbench

- Shares one FrameLink output among PORTS FrameLink inputs, with round-robin arbitration per whole frame.
- Once a port is granted, the grant is held from its first transferred word until its EOF word is transferred.
- Sits in front of FL_PIPE or any single-consumer FrameLink sink.
- A per-port enable mask lets software/config logic exclude inputs from arbitration.

---
 rtl/fl_frame_arbiter.sv | 130 +++++++++++++
 tb/tb_fl_frame_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fl_frame_arbiter.sv
// Frame-granular round-robin arbiter: merges PORTS FrameLink inputs onto one
// FrameLink output, holding each grant from the first word until the EOF word.
module fl_frame_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PORTS      = 4,
    localparam int unsigned RW        = (DATA_WIDTH >= 16) ? $clog2(DATA_WIDTH / 8) : 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [PORTS-1:0]          PORT_EN,
    input  logic [PORTS*DATA_WIDTH-1:0] RX_DATA,
    input  logic [PORTS*RW-1:0]       RX_REM,
    input  logic [PORTS-1:0]          RX_SOF_N,
    input  logic [PORTS-1:0]          RX_EOF_N,
    input  logic [PORTS-1:0]          RX_SOP_N,
    input  logic [PORTS-1:0]          RX_EOP_N,
    input  logic [PORTS-1:0]          RX_SRC_RDY_N,
    output logic [PORTS-1:0]          RX_DST_RDY_N,
    output logic [DATA_WIDTH-1:0]     TX_DATA,
    output logic [RW-1:0]             TX_REM,
    output logic                      TX_SOF_N,
    output logic                      TX_EOF_N,
    output logic                      TX_SOP_N,
    output logic                      TX_EOP_N,
    output logic                      TX_SRC_RDY_N,
    input  logic                      TX_DST_RDY_N,
    output logic [PORTS-1:0]          GRANT
);

    localparam int unsigned PW = $clog2(PORTS);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [PW-1:0] LAST_PORT = PW'(PORTS - 1);

    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    gnt_idx_q, gnt_idx_d;
    logic [PORTS-1:0] grant_q, grant_d;

    logic [DATA_WIDTH-1:0] rx_data_a [PORTS];
    logic [RW-1:0]         rx_rem_a  [PORTS];

    logic [PORTS-1:0] req;
    logic             pick_vld;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    cand_idx;
    logic             locked_xfer;
    logic             locked_eof;

    // Per-port views of the packed input buses.
    for (genvar i = 0; i < PORTS; i++) begin : g_unpack
        assign rx_data_a[i] = RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        assign rx_rem_a[i]  = RX_REM[i*RW +: RW];
    end

    assign req = ~RX_SRC_RDY_N & PORT_EN;

    // Round-robin pick: first requesting port at or above rr_ptr, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_ptr_q;
        cand_idx = rr_ptr_q;
        for (int unsigned k = 0; k < PORTS; k++) begin
            cand_idx = PW'((32'(rr_ptr_q) + k) % PORTS);
            if (!pick_vld && req[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    assign locked_xfer = (state_q == ST_LOCKED) && !RX_SRC_RDY_N[gnt_idx_q] && !TX_DST_RDY_N;
    assign locked_eof  = locked_xfer && !RX_EOF_N[gnt_idx_q];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        grant_d   = grant_q;
        if (state_q == ST_IDLE) begin
            if (pick_vld) begin
                state_d   = ST_LOCKED;
                gnt_idx_d = pick_idx;
                grant_d   = PORTS'(1) << pick_idx;
            end
        end else begin
            if (locked_eof) begin
                state_d   = ST_IDLE;
                rr_ptr_d  = (gnt_idx_q == LAST_PORT) ? '0 : gnt_idx_q + PW'(1);
                gnt_idx_d = '0;
                grant_d   = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            grant_q   <= grant_d;
        end
    end

    // Zero-latency datapath mux; gnt_idx_q rests at port 0 while idle.
    always_comb begin
        TX_DATA      = rx_data_a[gnt_idx_q];
        TX_REM       = rx_rem_a[gnt_idx_q];
        TX_SOF_N     = RX_SOF_N[gnt_idx_q];
        TX_EOF_N     = RX_EOF_N[gnt_idx_q];
        TX_SOP_N     = RX_SOP_N[gnt_idx_q];
        TX_EOP_N     = RX_EOP_N[gnt_idx_q];
        TX_SRC_RDY_N = 1'b1;
        RX_DST_RDY_N = '1;
        if (state_q == ST_LOCKED) begin
            TX_SRC_RDY_N            = RX_SRC_RDY_N[gnt_idx_q];
            RX_DST_RDY_N[gnt_idx_q] = TX_DST_RDY_N;
        end
    end

    assign GRANT = grant_q;

endmodule

// File: tb/tb_fl_frame_arbiter.sv
// Directed bench for fl_frame_arbiter with PORTS=4, DATA_WIDTH=32.
module tb_fl_frame_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned NP = 4;
    localparam int unsigned RW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     port_en;
    logic [NP*DW-1:0]  rx_data;
    logic [NP*RW-1:0]  rx_rem;
    logic [NP-1:0]     rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n;
    logic [NP-1:0]     rx_dst_rdy_n;
    logic [DW-1:0]     tx_data;
    logic [RW-1:0]     tx_rem;
    logic              tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_rdy_n;
    logic              tx_dst_rdy_n;
    logic [NP-1:0]     grant;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fl_frame_arbiter #(.DATA_WIDTH(DW), .PORTS(NP)) dut (
        .CLK(clk), .RESET(reset), .PORT_EN(port_en),
        .RX_DATA(rx_data), .RX_REM(rx_rem),
        .RX_SOF_N(rx_sof_n), .RX_EOF_N(rx_eof_n), .RX_SOP_N(rx_sop_n), .RX_EOP_N(rx_eop_n),
        .RX_SRC_RDY_N(rx_src_rdy_n), .RX_DST_RDY_N(rx_dst_rdy_n),
        .TX_DATA(tx_data), .TX_REM(tx_rem),
        .TX_SOF_N(tx_sof_n), .TX_EOF_N(tx_eof_n), .TX_SOP_N(tx_sop_n), .TX_EOP_N(tx_eop_n),
        .TX_SRC_RDY_N(tx_src_rdy_n), .TX_DST_RDY_N(tx_dst_rdy_n),
        .GRANT(grant)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input int p, input logic [31:0] d, input logic [1:0] rem,
                         input logic sof, input logic eof, input logic vld);
        rx_data[p*DW +: DW]  = d;
        rx_rem[p*RW +: RW]   = rem;
        rx_sof_n[p]          = !sof;
        rx_eof_n[p]          = !eof;
        rx_sop_n[p]          = !sof;
        rx_eop_n[p]          = !eof;
        rx_src_rdy_n[p]      = !vld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int f, ph, ep;
        int wc[NP];
        int fc[NP];
        logic hs0, hs2;
        int ord3[3];
        int ord2[2];

        ord3[0] = 0; ord3[1] = 1; ord3[2] = 3;
        ord2[0] = 1; ord2[1] = 3;
        for (int p = 0; p < NP; p++) begin
            wc[p] = 0;
            fc[p] = 0;
        end

        reset        = 1'b1;
        port_en      = 4'b1111;
        tx_dst_rdy_n = 1'b0;
        rx_data      = '0;
        rx_rem       = '0;
        rx_sof_n     = '1;
        rx_eof_n     = '1;
        rx_sop_n     = '1;
        rx_eop_n     = '1;
        rx_src_rdy_n = '1;
        step();
        step();
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_tx_src", 64'(tx_src_rdy_n), 64'h1);
        check("rst_rx_dst", 64'(rx_dst_rdy_n), 64'hF);
        check("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
        reset = 1'b0;
        step();

        // Single-port 3-word frame on port 1
        drive(1, 32'h11, 2'd0, 1'b1, 1'b0, 1'b1);
        #1;
        check("sp_bubble_grant", 64'(grant), 64'h0);
        check("sp_bubble_src", 64'(tx_src_rdy_n), 64'h1);
        step();
        check("sp_grant", 64'(grant), 64'h2);
        check("sp_w0_data", 64'(tx_data), 64'h11);
        check("sp_w0_sof", 64'(tx_sof_n), 64'h0);
        check("sp_w0_eof", 64'(tx_eof_n), 64'h1);
        check("sp_w0_src", 64'(tx_src_rdy_n), 64'h0);
        check("sp_rx_dst", 64'(rx_dst_rdy_n), 64'hD);
        step();
        drive(1, 32'h12, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        check("sp_w1_data", 64'(tx_data), 64'h12);
        check("sp_w1_sof", 64'(tx_sof_n), 64'h1);
        step();
        drive(1, 32'h13, 2'd3, 1'b0, 1'b1, 1'b1);
        #1;
        check("sp_w2_data", 64'(tx_data), 64'h13);
        check("sp_w2_eof", 64'(tx_eof_n), 64'h0);
        check("sp_w2_rem", 64'(tx_rem), 64'h3);
        step();
        drive(1, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("sp_idle_grant", 64'(grant), 64'h0);
        check("sp_idle_src", 64'(tx_src_rdy_n), 64'h1);
        check("sp_rr_ptr", 64'(dut.rr_ptr_q), 64'h2);
        step();

        // Round robin between ports 0 and 2, 2-word frames; rr_ptr=2 so port 2 first
        for (int c = 0; c < 12; c++) begin
            f  = c / 3;
            ph = c % 3;
            ep = (f % 2 == 0) ? 2 : 0;
            for (int p = 0; p < NP; p += 2)
                drive(p, 32'((p << 8) | (fc[p] << 4) | wc[p]), 2'd0, wc[p] == 0, wc[p] == 1, 1'b1);
            #1;
            if (ph == 0) begin
                check("rr_idle_grant", 64'(grant), 64'h0);
                check("rr_idle_src", 64'(tx_src_rdy_n), 64'h1);
            end else begin
                check("rr_grant", 64'(grant), 64'(1 << ep));
                check("rr_src", 64'(tx_src_rdy_n), 64'h0);
                check("rr_data", 64'(tx_data), 64'((ep << 8) | ((f / 2) << 4) | (ph - 1)));
                check("rr_eof", 64'(tx_eof_n), (ph == 2) ? 64'h0 : 64'h1);
            end
            hs0 = !rx_src_rdy_n[0] && !rx_dst_rdy_n[0];
            hs2 = !rx_src_rdy_n[2] && !rx_dst_rdy_n[2];
            step();
            if (hs0) begin
                wc[0]++;
                if (wc[0] == 2) begin wc[0] = 0; fc[0]++; end
            end
            if (hs2) begin
                wc[2]++;
                if (wc[2] == 2) begin wc[2] = 0; fc[2]++; end
            end
        end
        drive(0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        drive(2, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rr_end_ptr", 64'(dut.rr_ptr_q), 64'h1);
        step();

        // Backpressure on port 3 after word 1
        drive(3, 32'h31, 2'd0, 1'b1, 1'b0, 1'b1);
        step();
        check("bp_grant", 64'(grant), 64'h8);
        check("bp_w0_data", 64'(tx_data), 64'h31);
        check("bp_rx_dst", 64'(rx_dst_rdy_n), 64'h7);
        step();
        drive(3, 32'h32, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        check("bp_w1_data", 64'(tx_data), 64'h32);
        step();
        drive(3, 32'h33, 2'd0, 1'b0, 1'b0, 1'b1);
        tx_dst_rdy_n = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            check("bp_stall_rx_dst", 64'(rx_dst_rdy_n), 64'hF);
            check("bp_stall_data", 64'(tx_data), 64'h33);
            check("bp_stall_grant", 64'(grant), 64'h8);
            step();
        end
        tx_dst_rdy_n = 1'b0;
        #1;
        check("bp_w2_data", 64'(tx_data), 64'h33);
        check("bp_w2_rx_dst", 64'(rx_dst_rdy_n), 64'h7);
        step();
        drive(3, 32'h34, 2'd2, 1'b0, 1'b1, 1'b1);
        #1;
        check("bp_w3_data", 64'(tx_data), 64'h34);
        check("bp_w3_eof", 64'(tx_eof_n), 64'h0);
        check("bp_w3_grant", 64'(grant), 64'h8);
        step();
        drive(3, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("bp_idle_grant", 64'(grant), 64'h0);
        check("bp_rr_wrap", 64'(dut.rr_ptr_q), 64'h0);
        step();

        // Enable mask 1011, all ports sending single-word frames
        port_en = 4'b1011;
        for (int c = 0; c < 12; c++) begin
            f  = c / 2;
            ph = c % 2;
            ep = ord3[f % 3];
            for (int p = 0; p < NP; p++)
                drive(p, 32'(32'h40 + p), 2'd0, 1'b1, 1'b1, 1'b1);
            #1;
            if (ph == 0) begin
                check("em_idle_grant", 64'(grant), 64'h0);
            end else begin
                check("em_grant", 64'(grant), 64'(1 << ep));
                check("em_data", 64'(tx_data), 64'(32'h40 + ep));
            end
            step();
        end

        // Port 0 two-word frame; its enable is cleared while locked
        drive(0, 32'h50, 2'd0, 1'b1, 1'b0, 1'b1);
        #1;
        check("em0_bubble", 64'(grant), 64'h0);
        step();
        port_en = 4'b1010;
        #1;
        check("em0_grant", 64'(grant), 64'h1);
        check("em0_w0", 64'(tx_data), 64'h50);
        step();
        drive(0, 32'h51, 2'd0, 1'b0, 1'b1, 1'b1);
        #1;
        check("em0_hold_grant", 64'(grant), 64'h1);
        check("em0_w1", 64'(tx_data), 64'h51);
        check("em0_eof", 64'(tx_eof_n), 64'h0);
        step();
        for (int c = 0; c < 8; c++) begin
            f  = c / 2;
            ph = c % 2;
            ep = ord2[f % 2];
            for (int p = 0; p < NP; p++)
                drive(p, 32'(32'h40 + p), 2'd0, 1'b1, 1'b1, 1'b1);
            #1;
            if (ph == 0) begin
                check("em2_idle_grant", 64'(grant), 64'h0);
            end else begin
                check("em2_grant", 64'(grant), 64'(1 << ep));
                check("em2_data", 64'(tx_data), 64'(32'h40 + ep));
            end
            step();
        end
        for (int p = 0; p < NP; p++)
            drive(p, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        port_en = 4'b1111;
        #1;
        check("em2_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
        step();

        // Single-word frame on port 0
        drive(0, 32'h60, 2'd1, 1'b1, 1'b1, 1'b1);
        step();
        check("sw_grant", 64'(grant), 64'h1);
        check("sw_sof", 64'(tx_sof_n), 64'h0);
        check("sw_eof", 64'(tx_eof_n), 64'h0);
        check("sw_data", 64'(tx_data), 64'h60);
        step();
        drive(0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("sw_idle_grant", 64'(grant), 64'h0);
        check("sw_idle_src", 64'(tx_src_rdy_n), 64'h1);
        check("sw_rr_ptr", 64'(dut.rr_ptr_q), 64'h1);

        // Reset during word 1 of a port 1 frame
        drive(1, 32'h70, 2'd0, 1'b1, 1'b0, 1'b1);
        step();
        check("rs_grant", 64'(grant), 64'h2);
        step();
        drive(1, 32'h71, 2'd0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        check("rs_w1_data", 64'(tx_data), 64'h71);
        step();
        check("rs_after_grant", 64'(grant), 64'h0);
        check("rs_after_src", 64'(tx_src_rdy_n), 64'h1);
        check("rs_after_rx_dst", 64'(rx_dst_rdy_n), 64'hF);
        check("rs_after_rr", 64'(dut.rr_ptr_q), 64'h0);
        reset = 1'b0;
        drive(0, 32'h61, 2'd0, 1'b1, 1'b1, 1'b1);
        drive(1, 32'h72, 2'd0, 1'b1, 1'b1, 1'b1);
        #1;
        check("rs_bubble", 64'(grant), 64'h0);
        step();
        check("rs_lowest_grant", 64'(grant), 64'h1);
        check("rs_lowest_data", 64'(tx_data), 64'h61);
        step();
        for (int p = 0; p < NP; p++)
            drive(p, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();

        // All ports disabled: stays idle despite a request
        port_en = 4'b0000;
        drive(2, 32'h80, 2'd0, 1'b1, 1'b1, 1'b1);
        step();
        step();
        check("dis_grant", 64'(grant), 64'h0);
        check("dis_src", 64'(tx_src_rdy_n), 64'h1);
        check("dis_rx_dst", 64'(rx_dst_rdy_n), 64'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
